// File: rtl/cb_heep_multi_start_ctrl_if.sv
// Control interface between the register file and the multi-core launch controller.
// The register file side is the master; the controller is the slave.
interface cb_heep_multi_start_ctrl_if #(
    parameter int NCORES    = 3,
    parameter int ADDR_W    = 32,
    parameter int TIMEOUT_W = 16
);
    logic                 start_i;
    logic                 abort_i;
    logic [NCORES-1:0]    core_mask_i;
    logic [ADDR_W-1:0]    boot_addr_i;
    logic [TIMEOUT_W-1:0] timeout_i;
    logic [NCORES-1:0]    end_sw_i;
    logic [NCORES-1:0]    start_o;
    logic [ADDR_W-1:0]    boot_addr_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 timeout_o;
    logic                 aborted_o;
    logic [NCORES-1:0]    done_mask_o;

    modport master (
        output start_i, abort_i, core_mask_i, boot_addr_i, timeout_i, end_sw_i,
        input  start_o, boot_addr_o, busy_o, done_o, timeout_o, aborted_o, done_mask_o
    );

    modport slave (
        input  start_i, abort_i, core_mask_i, boot_addr_i, timeout_i, end_sw_i,
        output start_o, boot_addr_o, busy_o, done_o, timeout_o, aborted_o, done_mask_o
    );
endinterface

// File: rtl/cb_heep_multi_start_ctrl.sv
// N-core launch/completion controller: starts the masked cores, tracks each core's
// end-of-software rising edge, and reports done / watchdog timeout / abort as pulses.
//
//  state | meaning
//  IDLE  | waiting for a start request with a non-empty core mask
//  RUN   | job running; collecting end-of-software edges, watchdog counting down
module cb_heep_multi_start_ctrl #(
    parameter int NCORES    = 3,
    parameter int ADDR_W    = 32,
    parameter int TIMEOUT_W = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    cb_heep_multi_start_ctrl_if.slave     bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t               r_state;
    logic [NCORES-1:0]    r_mask;
    logic [NCORES-1:0]    r_end_sw_q;
    logic [TIMEOUT_W-1:0] r_cnt;
    logic [NCORES-1:0]    r_start;
    logic [ADDR_W-1:0]    r_boot_addr;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_timeout;
    logic                 r_aborted;
    logic [NCORES-1:0]    r_done_mask;

    logic [NCORES-1:0]    w_new_done;
    logic [NCORES-1:0]    w_finished;
    logic                 w_complete;
    logic                 w_expire;

    // A level already high at launch is not an edge; only a fresh rise counts.
    assign w_new_done = bus.end_sw_i & ~r_end_sw_q & r_mask;
    assign w_finished = r_done_mask | w_new_done;
    assign w_complete = (w_finished == r_mask);
    assign w_expire   = (r_cnt == TIMEOUT_W'(1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_mask      <= '0;
            r_end_sw_q  <= '0;
            r_cnt       <= '0;
            r_start     <= '0;
            r_boot_addr <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_aborted   <= 1'b0;
            r_done_mask <= '0;
        end else begin
            r_end_sw_q <= bus.end_sw_i;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
            r_aborted  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.start_i && (bus.core_mask_i != '0)) begin
                        r_mask      <= bus.core_mask_i;
                        r_boot_addr <= bus.boot_addr_i;
                        r_cnt       <= bus.timeout_i;
                        r_done_mask <= '0;
                        r_start     <= bus.core_mask_i;
                        r_busy      <= 1'b1;
                        r_state     <= RUN;
                    end
                end
                RUN: begin
                    r_done_mask <= w_finished;
                    r_start     <= r_start & ~w_new_done;
                    // A zero count means the watchdog is disabled and never moves.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - TIMEOUT_W'(1);
                    end
                    if (bus.abort_i) begin
                        r_aborted <= 1'b1;
                        r_start   <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end else if (w_complete) begin
                        r_done  <= 1'b1;
                        r_start <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_expire) begin
                        r_timeout <= 1'b1;
                        r_start   <= '0;
                        r_busy    <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.start_o     = r_start;
    assign bus.boot_addr_o = r_boot_addr;
    assign bus.busy_o      = r_busy;
    assign bus.done_o      = r_done;
    assign bus.timeout_o   = r_timeout;
    assign bus.aborted_o   = r_aborted;
    assign bus.done_mask_o = r_done_mask;
endmodule

// File: tb/tb_cb_heep_multi_start_ctrl.sv
// Directed and randomized checks of the multi-core launch controller against a
// job-level reference model (pending cores, elapsed cycles since launch).
module tb_cb_heep_multi_start_ctrl;
    localparam int NC = 3;
    localparam int AW = 32;
    localparam int TW = 16;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    cb_heep_multi_start_ctrl_if #(.NCORES(NC), .ADDR_W(AW), .TIMEOUT_W(TW)) bus ();

    cb_heep_multi_start_ctrl #(.NCORES(NC), .ADDR_W(AW), .TIMEOUT_W(TW)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a job is a set of cores, a set already finished, and
    // a count of cycles spent running compared against the watchdog limit.
    logic          m_run;
    logic [NC-1:0] m_mask;
    logic [NC-1:0] m_done;
    logic [NC-1:0] m_prev;
    logic [AW-1:0] m_boot;
    int            m_limit;
    int            m_elapsed;
    logic          e_done, e_to, e_ab;

    task automatic model_reset();
        m_run = 1'b0; m_mask = '0; m_done = '0; m_prev = '0; m_boot = '0;
        m_limit = 0; m_elapsed = 0; e_done = 1'b0; e_to = 1'b0; e_ab = 1'b0;
    endtask

    task automatic model_update(input logic st, input logic ab, input logic [NC-1:0] msk,
                                input logic [NC-1:0] es, input logic [AW-1:0] ba,
                                input logic [TW-1:0] tmo);
        logic [NC-1:0] rise;
        rise   = es & ~m_prev;
        m_prev = es;
        e_done = 1'b0; e_to = 1'b0; e_ab = 1'b0;
        if (!m_run) begin
            if (st && msk != '0) begin
                m_run = 1'b1; m_mask = msk; m_boot = ba; m_limit = int'(tmo);
                m_elapsed = 0; m_done = '0;
            end
        end else begin
            m_done    = m_done | (rise & m_mask);
            m_elapsed = m_elapsed + 1;
            if (ab) begin
                m_run = 1'b0; e_ab = 1'b1;
            end else if (m_done == m_mask) begin
                m_run = 1'b0; e_done = 1'b1;
            end else if (m_limit != 0 && m_elapsed == m_limit) begin
                m_run = 1'b0; e_to = 1'b1;
            end
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        check({where, ".start_o"},     64'(bus.start_o),     64'(m_run ? (m_mask & ~m_done) : '0));
        check({where, ".boot_addr_o"}, 64'(bus.boot_addr_o), 64'(m_boot));
        check({where, ".busy_o"},      64'(bus.busy_o),      64'(m_run));
        check({where, ".done_o"},      64'(bus.done_o),      64'(e_done));
        check({where, ".timeout_o"},   64'(bus.timeout_o),   64'(e_to));
        check({where, ".aborted_o"},   64'(bus.aborted_o),   64'(e_ab));
        check({where, ".done_mask_o"}, 64'(bus.done_mask_o), 64'(m_done));
    endtask

    task automatic step(input string where);
        logic st, ab;
        logic [NC-1:0] msk, es;
        logic [AW-1:0] ba;
        logic [TW-1:0] tmo;
        st = bus.start_i; ab = bus.abort_i; msk = bus.core_mask_i; es = bus.end_sw_i;
        ba = bus.boot_addr_i; tmo = bus.timeout_i;
        @(posedge clk_i);
        model_update(st, ab, msk, es, ba, tmo);
        #1;
        check_all(where);
    endtask

    task automatic launch(input logic [NC-1:0] msk, input logic [AW-1:0] ba,
                          input logic [TW-1:0] tmo, input string where);
        bus.start_i = 1'b1; bus.core_mask_i = msk; bus.boot_addr_i = ba; bus.timeout_i = tmo;
        step(where);
        bus.start_i = 1'b0;
    endtask

    initial begin
        bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.core_mask_i = '0;
        bus.boot_addr_i = '0; bus.timeout_i = '0; bus.end_sw_i = '0;
        model_reset();
        #12;
        check_all("reset");
        rst_ni = 1'b1;

        // Basic two-core job, cores finishing one after another.
        launch(3'b101, 32'h1C00_0080, 16'd0, "t1_launch");
        check("t1_start_fixed", 64'(bus.start_o), 64'(3'b101));
        check("t1_boot_fixed", 64'(bus.boot_addr_o), 64'h1C00_0080);
        step("t1_idle");
        bus.end_sw_i = 3'b001; step("t1_core0");
        check("t1_start_after_core0", 64'(bus.start_o), 64'(3'b100));
        bus.end_sw_i = 3'b101; step("t1_core2");
        check("t1_done_fixed", 64'(bus.done_o), 64'd1);
        check("t1_done_mask_fixed", 64'(bus.done_mask_o), 64'(3'b101));
        bus.end_sw_i = 3'b000; step("t1_after");

        // Simultaneous edges; unmasked core ignored.
        launch(3'b011, 32'h0000_1000, 16'd0, "t2_launch");
        bus.end_sw_i = 3'b100; step("t2_unmasked");
        bus.end_sw_i = 3'b111; step("t2_both");
        check("t2_done_fixed", 64'(bus.done_o), 64'd1);
        step("t2_pulse_end");
        bus.end_sw_i = 3'b000; step("t2_drop");

        // Watchdog expiry, then a completion racing the last watchdog cycle.
        launch(3'b001, 32'h0000_2000, 16'd10, "t3_launch");
        repeat (10) step("t3_wait");
        check("t3_timeout_fixed", 64'(bus.timeout_o), 64'd1);
        launch(3'b001, 32'h0000_2000, 16'd10, "t3b_launch");
        repeat (9) step("t3b_wait");
        bus.end_sw_i = 3'b001; step("t3b_race");
        check("t3b_done_fixed", 64'(bus.done_o), 64'd1);
        check("t3b_no_timeout", 64'(bus.timeout_o), 64'd0);
        bus.end_sw_i = 3'b000; step("t3b_drop");

        // Level already high at launch must not count.
        bus.end_sw_i = 3'b001; step("t4_pre");
        launch(3'b001, 32'h0000_3000, 16'd0, "t4_launch");
        repeat (3) step("t4_held");
        check("t4_still_busy", 64'(bus.busy_o), 64'd1);
        bus.end_sw_i = 3'b000; step("t4_low");
        bus.end_sw_i = 3'b001; step("t4_rise");
        check("t4_done_fixed", 64'(bus.done_o), 64'd1);
        bus.end_sw_i = 3'b000; step("t4_drop");

        // Empty mask, start during RUN, abort in RUN and IDLE.
        launch(3'b000, 32'hDEAD_0000, 16'd5, "t5_empty");
        check("t5_not_busy", 64'(bus.busy_o), 64'd0);
        launch(3'b110, 32'hAAAA_0000, 16'd0, "t5_launch");
        launch(3'b001, 32'hBBBB_0000, 16'd3, "t5_restart");
        check("t5_boot_kept", 64'(bus.boot_addr_o), 64'hAAAA_0000);
        bus.abort_i = 1'b1; step("t5_abort"); bus.abort_i = 1'b0;
        check("t5_aborted_fixed", 64'(bus.aborted_o), 64'd1);
        bus.abort_i = 1'b1; step("t5_idle_abort"); bus.abort_i = 1'b0;
        check("t5_no_abort_idle", 64'(bus.aborted_o), 64'd0);

        // Asynchronous reset mid-job, then a fresh job.
        launch(3'b111, 32'h1234_5678, 16'd50, "t6_launch");
        step("t6_run");
        rst_ni = 1'b0;
        #2;
        model_reset();
        check_all("t6_async_rst");
        rst_ni = 1'b1;
        launch(3'b010, 32'h0C0F_FEE0, 16'd0, "t6_fresh");
        check("t6_start_fixed", 64'(bus.start_o), 64'(3'b010));
        bus.end_sw_i = 3'b010; step("t6_done");
        bus.end_sw_i = 3'b000; step("t6_drop");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            bus.start_i     = ($urandom_range(0, 7) == 0);
            bus.abort_i     = ($urandom_range(0, 39) == 0);
            bus.core_mask_i = NC'($urandom);
            bus.boot_addr_i = $urandom;
            bus.timeout_i   = ($urandom_range(0, 3) == 0) ? 16'd0 : TW'($urandom_range(1, 25));
            for (int k = 0; k < NC; k++)
                if ($urandom_range(0, 5) == 0) bus.end_sw_i[k] = ~bus.end_sw_i[k];
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
